// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port among NUM_CH cache requestors.
module mem_arbiter #(
  parameter int data_size = 32,
  parameter int mem_size  = 16,
  parameter int NUM_CH    = 2,
  parameter int MEM_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             req_en_R,
  input  logic [NUM_CH-1:0]             req_en_W,
  input  logic [NUM_CH*mem_size-1:0]    req_addr,
  input  logic [NUM_CH*data_size-1:0]   req_wdata,
  output logic [data_size-1:0]          req_rdata,
  output logic [NUM_CH-1:0]             req_done,
  output logic [NUM_CH-1:0]             grant,
  output logic                          busy,
  output logic [mem_size-1:0]           mem_addr,
  output logic                          mem_en_R,
  output logic                          mem_en_W,
  output logic [data_size-1:0]          mem_wdata,
  input  logic [data_size-1:0]          mem_rdata
);
  localparam int CW = $clog2(NUM_CH);
  localparam int LW = $clog2(MEM_LAT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t               state_q, state_d;
  logic [CW-1:0]        rr_q, rr_d, chan_q, chan_d, sel;
  logic [LW-1:0]        lat_q, lat_d;
  logic                 wr_q, wr_d, found;
  logic [mem_size-1:0]  addr_q, addr_d;
  logic [data_size-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NUM_CH-1:0]    req, chan_oh;
  assign req     = req_en_R | req_en_W;
  assign chan_oh = NUM_CH'(1) << chan_q;
  // Search starts one past the last winner so the previous owner has lowest priority.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!found && req[(int'(rr_q) + i) % NUM_CH]) begin
        found = 1'b1;
        sel   = CW'((int'(rr_q) + i) % NUM_CH);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    chan_d  = chan_q;
    lat_d   = lat_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = ACCESS;
        chan_d  = sel;
        rr_d    = sel;
        lat_d   = '0;
        wr_d    = req_en_W[sel];
        addr_d  = req_addr[int'(sel)*mem_size +: mem_size];
        wdata_d = req_wdata[int'(sel)*data_size +: data_size];
      end
      ACCESS: begin
        lat_d = lat_q + LW'(1);
        if (lat_q == LW'(MEM_LAT - 1)) begin
          state_d = RESP;
          rdata_d = wr_q ? rdata_q : mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= CW'(NUM_CH - 1);
      chan_q  <= '0;
      lat_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      chan_q  <= chan_d;
      lat_q   <= lat_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  assign busy      = state_q != IDLE;
  assign grant     = busy ? chan_oh : '0;
  assign req_done  = state_q == RESP ? chan_oh : '0;
  assign mem_en_R  = state_q == ACCESS && !wr_q;
  assign mem_en_W  = state_q == ACCESS && wr_q;
  assign mem_addr  = state_q == ACCESS ? addr_q : '0;
  assign mem_wdata = state_q == ACCESS ? wdata_q : '0;
  assign req_rdata = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter over three parameter sets sharing clk and rst.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  logic [1:0]   a_en_R, a_en_W, a_done, a_grant;
  logic [31:0]  a_addr, a_rdata, a_mwdata, a_mrdata;
  logic [63:0]  a_wdata;
  logic [15:0]  a_maddr;
  logic         a_busy, a_mR, a_mW;
  logic [3:0]   b_en_R, b_en_W, b_done, b_grant;
  logic [63:0]  b_addr;
  logic [127:0] b_wdata;
  logic [31:0]  b_rdata, b_mwdata, b_mrdata;
  logic [15:0]  b_maddr;
  logic         b_busy, b_mR, b_mW;
  logic [1:0]   c_en_R, c_en_W, c_done, c_grant;
  logic [31:0]  c_addr, c_rdata, c_mwdata, c_mrdata;
  logic [63:0]  c_wdata;
  logic [15:0]  c_maddr;
  logic         c_busy, c_mR, c_mW;
  logic [22:0]  a_obs, c_obs;
  assign a_obs    = {a_mR, a_mW, a_maddr, a_grant, a_done, a_busy};
  assign c_obs    = {c_mR, c_mW, c_maddr, c_grant, c_done, c_busy};
  assign b_mrdata = {16'hBEEF, b_maddr};
  mem_arbiter #(.NUM_CH(2), .MEM_LAT(2)) dut_a (
    .clk(clk), .rst(rst), .req_en_R(a_en_R), .req_en_W(a_en_W), .req_addr(a_addr),
    .req_wdata(a_wdata), .req_rdata(a_rdata), .req_done(a_done), .grant(a_grant), .busy(a_busy),
    .mem_addr(a_maddr), .mem_en_R(a_mR), .mem_en_W(a_mW), .mem_wdata(a_mwdata), .mem_rdata(a_mrdata));
  mem_arbiter #(.NUM_CH(4), .MEM_LAT(1)) dut_b (
    .clk(clk), .rst(rst), .req_en_R(b_en_R), .req_en_W(b_en_W), .req_addr(b_addr),
    .req_wdata(b_wdata), .req_rdata(b_rdata), .req_done(b_done), .grant(b_grant), .busy(b_busy),
    .mem_addr(b_maddr), .mem_en_R(b_mR), .mem_en_W(b_mW), .mem_wdata(b_mwdata), .mem_rdata(b_mrdata));
  mem_arbiter #(.NUM_CH(2), .MEM_LAT(3)) dut_c (
    .clk(clk), .rst(rst), .req_en_R(c_en_R), .req_en_W(c_en_W), .req_addr(c_addr),
    .req_wdata(c_wdata), .req_rdata(c_rdata), .req_done(c_done), .grant(c_grant), .busy(c_busy),
    .mem_addr(c_maddr), .mem_en_R(c_mR), .mem_en_W(c_mW), .mem_wdata(c_mwdata), .mem_rdata(c_mrdata));
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic do_reset;
    rst = 1'b0;
    tick;
    rst = 1'b1;
  endtask
  task automatic clear_reqs;
    a_en_R = '0; a_en_W = '0; b_en_R = '0; b_en_W = '0; c_en_R = '0; c_en_W = '0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    clear_reqs;
    a_addr = '0; a_wdata = '0; a_mrdata = '0; b_addr = '0; b_wdata = '0;
    c_addr = '0; c_wdata = '0; c_mrdata = '0;
    #2 rst = 1'b0;
    a_en_R = 2'($urandom); a_en_W = 2'($urandom); a_addr = $urandom; a_mrdata = $urandom;
    b_en_R = 4'($urandom); b_en_W = 4'($urandom); b_addr = {$urandom, $urandom};
    c_en_R = 2'($urandom); c_en_W = 2'($urandom); c_addr = $urandom;
    repeat (3) tick;
    checks++;
    if ({a_obs, a_rdata, a_mwdata} !== '0) begin
      errors++; $display("FAIL reset_a got %h exp 0", {a_obs, a_rdata, a_mwdata});
    end
    checks++;
    if ({b_mR, b_mW, b_maddr, b_grant, b_done, b_busy, b_rdata, b_mwdata} !== '0) begin
      errors++; $display("FAIL reset_b got %h exp 0", {b_mR, b_mW, b_maddr, b_grant, b_done, b_busy, b_rdata, b_mwdata});
    end
    checks++;
    if ({c_obs, c_rdata, c_mwdata} !== '0) begin
      errors++; $display("FAIL reset_c got %h exp 0", {c_obs, c_rdata, c_mwdata});
    end
    clear_reqs;
    a_addr = '0; a_mrdata = '0; b_addr = '0; c_addr = '0;
    rst = 1'b1;
    tick;
  endtask
  task automatic test_single_read;
    a_addr = 32'h0000_0010; a_mrdata = 32'hDEADBEEF; a_en_R = 2'b01;
    checks++;
    if (a_busy !== 1'b0) begin
      errors++; $display("FAIL read_cycle0_busy got %b exp 0", a_busy);
    end
    for (int c = 1; c <= 2; c++) begin
      tick;
      checks++;
      if (a_obs !== {1'b1, 1'b0, 16'h0010, 2'b01, 2'b00, 1'b1}) begin
        errors++; $display("FAIL read_access%0d got %h exp %h", c, a_obs, {1'b1, 1'b0, 16'h0010, 2'b01, 2'b00, 1'b1});
      end
    end
    tick;
    checks++;
    if ({a_mR, a_mW, a_grant, a_done, a_busy, a_rdata} !== {1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL read_done got %h exp %h", {a_mR, a_mW, a_grant, a_done, a_busy, a_rdata}, {1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 32'hDEADBEEF});
    end
    a_en_R = '0;
    tick;
    checks++;
    if ({a_busy, a_done, a_grant, a_mR, a_rdata} !== {1'b0, 2'b00, 2'b00, 1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL read_idle got %h exp %h", {a_busy, a_done, a_grant, a_mR, a_rdata}, {1'b0, 2'b00, 2'b00, 1'b0, 32'hDEADBEEF});
    end
  endtask
  task automatic test_contention;
    do_reset;
    a_addr = {16'h0008, 16'h0004}; a_wdata = {32'h12345678, 32'h0}; a_mrdata = 32'hCAFEF00D;
    a_en_R = 2'b01; a_en_W = 2'b10;
    for (int c = 1; c <= 2; c++) begin
      tick;
      checks++;
      if (a_obs !== {1'b1, 1'b0, 16'h0004, 2'b01, 2'b00, 1'b1}) begin
        errors++; $display("FAIL cont_ch0_access%0d got %h exp %h", c, a_obs, {1'b1, 1'b0, 16'h0004, 2'b01, 2'b00, 1'b1});
      end
    end
    tick;
    checks++;
    if ({a_grant, a_done, a_rdata} !== {2'b01, 2'b01, 32'hCAFEF00D}) begin
      errors++; $display("FAIL cont_ch0_done got %h exp %h", {a_grant, a_done, a_rdata}, {2'b01, 2'b01, 32'hCAFEF00D});
    end
    a_en_R = '0; a_mrdata = 32'h11111111;
    tick;
    checks++;
    if ({a_busy, a_grant} !== 3'b000) begin
      errors++; $display("FAIL cont_idle got %b exp 000", {a_busy, a_grant});
    end
    for (int c = 1; c <= 2; c++) begin
      tick;
      checks++;
      if ({a_obs, a_mwdata} !== {1'b0, 1'b1, 16'h0008, 2'b10, 2'b00, 1'b1, 32'h12345678}) begin
        errors++; $display("FAIL cont_ch1_write%0d got %h exp %h", c, {a_obs, a_mwdata}, {1'b0, 1'b1, 16'h0008, 2'b10, 2'b00, 1'b1, 32'h12345678});
      end
    end
    tick;
    checks++;
    if ({a_grant, a_done, a_rdata} !== {2'b10, 2'b10, 32'hCAFEF00D}) begin
      errors++; $display("FAIL cont_ch1_done got %h exp %h", {a_grant, a_done, a_rdata}, {2'b10, 2'b10, 32'hCAFEF00D});
    end
    a_en_W = '0;
    tick;
  endtask
  task automatic test_both_enables;
    a_addr = {16'h0020, 16'h0000}; a_wdata = {32'hA5A5A5A5, 32'h0};
    a_en_R = 2'b10; a_en_W = 2'b10;
    for (int c = 1; c <= 2; c++) begin
      tick;
      checks++;
      if ({a_obs, a_mwdata} !== {1'b0, 1'b1, 16'h0020, 2'b10, 2'b00, 1'b1, 32'hA5A5A5A5}) begin
        errors++; $display("FAIL both_access%0d got %h exp %h", c, {a_obs, a_mwdata}, {1'b0, 1'b1, 16'h0020, 2'b10, 2'b00, 1'b1, 32'hA5A5A5A5});
      end
    end
    tick;
    checks++;
    if ({a_mR, a_mW, a_done, a_rdata} !== {1'b0, 1'b0, 2'b10, 32'hCAFEF00D}) begin
      errors++; $display("FAIL both_done got %h exp %h", {a_mR, a_mW, a_done, a_rdata}, {1'b0, 1'b0, 2'b10, 32'hCAFEF00D});
    end
    a_en_R = '0; a_en_W = '0;
    tick;
  endtask
  task automatic test_fairness;
    logic [3:0]  eg;
    logic [15:0] ea;
    do_reset;
    b_addr = {16'h0300, 16'h0200, 16'h0100, 16'h0000}; b_en_R = 4'hF;
    for (int k = 0; k < 5; k++) begin
      eg = 4'(1 << (k % 4));
      ea = 16'((k % 4) * 256);
      tick;
      checks++;
      if ({b_mR, b_grant, b_maddr, b_done} !== {1'b1, eg, ea, 4'b0000}) begin
        errors++; $display("FAIL fair_access%0d got %h exp %h", k, {b_mR, b_grant, b_maddr, b_done}, {1'b1, eg, ea, 4'b0000});
      end
      tick;
      checks++;
      if ({b_done, b_grant, b_rdata} !== {eg, eg, 16'hBEEF, ea}) begin
        errors++; $display("FAIL fair_done%0d got %h exp %h", k, {b_done, b_grant, b_rdata}, {eg, eg, 16'hBEEF, ea});
      end
      tick;
      checks++;
      if ({b_busy, b_done} !== 5'b0) begin
        errors++; $display("FAIL fair_idle%0d got %b exp 00000", k, {b_busy, b_done});
      end
    end
    b_en_R = '0;
    tick;
  endtask
  task automatic test_reset_mid;
    do_reset;
    c_addr = {16'h0000, 16'h0030}; c_mrdata = 32'h77777777; c_en_R = 2'b01;
    tick;
    tick;
    checks++;
    if (c_obs !== {1'b1, 1'b0, 16'h0030, 2'b01, 2'b00, 1'b1}) begin
      errors++; $display("FAIL mid_access2 got %h exp %h", c_obs, {1'b1, 1'b0, 16'h0030, 2'b01, 2'b00, 1'b1});
    end
    rst = 1'b0;
    c_en_R = 2'b11; c_addr = {16'h0040, 16'h0030};
    #1;
    checks++;
    if ({c_mR, c_mW, c_grant, c_busy, c_done} !== 6'b0) begin
      errors++; $display("FAIL mid_async_abort got %b exp 000000", {c_mR, c_mW, c_grant, c_busy, c_done});
    end
    tick;
    checks++;
    if ({c_done, c_busy, c_rdata} !== '0) begin
      errors++; $display("FAIL mid_held got %h exp 0", {c_done, c_busy, c_rdata});
    end
    rst = 1'b1;
    tick;
    checks++;
    if (c_obs !== {1'b1, 1'b0, 16'h0030, 2'b01, 2'b00, 1'b1}) begin
      errors++; $display("FAIL mid_ch0_wins got %h exp %h", c_obs, {1'b1, 1'b0, 16'h0030, 2'b01, 2'b00, 1'b1});
    end
    repeat (3) tick;
    checks++;
    if ({c_done, c_grant, c_rdata} !== {2'b01, 2'b01, 32'h77777777}) begin
      errors++; $display("FAIL mid_done got %h exp %h", {c_done, c_grant, c_rdata}, {2'b01, 2'b01, 32'h77777777});
    end
    c_en_R = '0;
    tick;
  endtask
  initial begin
    test_reset;
    test_single_read;
    test_contention;
    test_both_enables;
    test_fairness;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one external memory port among NUM_CH cache miss/write-back requestors, for example I$ and D$ on a unified memory.
- Successor to the fixed two-port cache/memory wiring in the top level. Adds a parametrised channel count, a parametrised memory latency, round-robin arbitration and a per-channel completion handshake.
- Sits between the cache `mem_*` ports and the external memory interface.

Parameters:
- data_size, 32, data word width
- mem_size, 16, address width
- NUM_CH, 2, number of requestor channels (>=2)
- MEM_LAT, 1, cycles the memory bus is held per access (>=1); read data is valid at the end of the last cycle

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- req_en_R  in  NUM_CH  per-channel read request
- req_en_W  in  NUM_CH  per-channel write request
- req_addr  in  NUM_CH*mem_size  packed addresses; channel i at [i*mem_size +: mem_size]
- req_wdata  in  NUM_CH*data_size  packed write data; channel i at [i*data_size +: data_size]
- req_rdata  out  data_size  read data for the completed channel; qualified by req_done
- req_done  out  NUM_CH  one-hot, 1-cycle completion pulse
- grant  out  NUM_CH  one-hot; channel currently owning the memory bus
- busy  out  1  high whenever state != IDLE
- mem_addr  out  mem_size  memory address
- mem_en_R  out  1  memory read enable
- mem_en_W  out  1  memory write enable
- mem_wdata  out  data_size  memory write data
- mem_rdata  in  data_size  memory read data

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, rr_ptr=NUM_CH-1, lat_cnt=0, req_rdata=0.
  - All outputs are 0 immediately. A transfer in flight is aborted with no req_done.
- Channel i is requesting when req_en_R[i] | req_en_W[i].
- If both req_en_R[i] and req_en_W[i] are high, the access is a write and the read is ignored.
- Requestor rule: hold addr, wdata and enables stable from assertion until req_done[i]. Deassert or change them in the cycle after req_done[i]. Violations are undefined.
- IDLE:
  - mem_en_R=mem_en_W=0, mem_addr=0, mem_wdata=0, grant=0.
  - If any channel is requesting: select the first requesting channel searching rr_ptr+1, rr_ptr+2, ... modulo NUM_CH.
  - On the selection, latch chan, op, addr and wdata; set rr_ptr=chan and lat_cnt=0; go to ACCESS.
  - Latched values are used for the whole transfer; later input changes are ignored.
- ACCESS:
  - mem_addr and mem_wdata come from the latched values. mem_en_R=(op==read), mem_en_W=(op==write). grant=onehot(chan).
  - Enables stay constant for exactly MEM_LAT cycles; lat_cnt increments each cycle.
  - On the last cycle (lat_cnt==MEM_LAT-1): for a read, capture mem_rdata into req_rdata at that clock edge, then go to RESP.
- RESP:
  - req_done=onehot(chan) for 1 cycle. grant stays onehot(chan). Memory enables are 0.
  - Next state is IDLE unconditionally.
  - req_rdata holds its value until the next read capture; writes do not modify it.
- Latency:
  - Request seen in IDLE at cycle 0 → ACCESS cycles 1..MEM_LAT → req_done at cycle MEM_LAT+1.
  - Back-to-back transfers repeat every MEM_LAT+2 cycles.
- Fairness: with all channels requesting continuously, grants rotate 0,1,...,NUM_CH-1,0,... Each channel waits at most (NUM_CH-1)*(MEM_LAT+2) cycles before being granted.
- Simultaneous new requests arriving during ACCESS or RESP are not sampled until IDLE.
- Out-of-range combinations do not exist: rr_ptr wraps from NUM_CH-1 to 0.
- lat_cnt width is clog2(MEM_LAT+1), minimum 1 bit.

Test Plan:
1. Reset: hold rst=0 with random requests → all outputs 0, busy=0, no mem enables. Release rst → ch0 holds first priority.
2. Single read: MEM_LAT=2, ch0 read addr 0x0010, memory returns 0xDEADBEEF → mem_en_R=1 and mem_addr=0x0010 in cycles 1-2; req_done=2'b01 at cycle 3 with req_rdata=0xDEADBEEF; busy falls at cycle 4.
3. Contention: after reset, ch0 read 0x0004 and ch1 write 0x0008 with data 0x12345678 asserted together → ch0 served first; then mem_en_W=1, mem_addr=0x0008, mem_wdata=0x12345678; req_done=2'b10; req_rdata unchanged by the write.
4. Fairness: NUM_CH=4, all channels request continuously, MEM_LAT=1 → grant sequence 0,1,2,3,0. Each req_done is 3 cycles apart.
5. Both enables on one channel: ch1 with req_en_R=req_en_W=1, addr 0x0020 → mem_en_W=1 and mem_en_R=0 throughout; req_done=2'b10.
6. Reset mid-transfer: rst=0 during the second ACCESS cycle of a MEM_LAT=3 read → mem_en_R drops asynchronously and no req_done occurs. After release, a pending ch1 request is not favoured; ch0 wins if requesting.
